seq_tx_sched: RTL



---
 rtl/seq_tx_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seq_tx_sched.sv
// rtl/seq_tx_sched.sv - round-robin serial frame transmitter for four requesters
// Frame: header, 32 payload bits MSB first, 8-bit additive checksum, then forced idle gap.
module seq_tx_sched #(
  parameter logic [7:0] HEAD_PAT = 8'hA5,
  parameter int         HEAD_LEN = 8,
  parameter int         GAP      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [127:0] payload,
  output logic [3:0]   grant,
  output logic         sdo,
  output logic         busy,
  output logic         done,
  output logic [1:0]   cur_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_DATA,
    S_SUM,
    S_GAP
  } state_t;

  // Header left-justified so the first bit to send always sits in bit 7.
  localparam logic [7:0] HEAD_ALIGNED = HEAD_PAT << (8 - HEAD_LEN);
  localparam logic [5:0] HEAD_LAST    = 6'(HEAD_LEN - 1);
  localparam logic [5:0] DATA_LAST    = 6'd31;
  localparam logic [5:0] SUM_LAST     = 6'd7;
  localparam logic [5:0] GAP_LAST     = 6'(GAP - 1);

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [31:0] shreg, shreg_nxt;
  logic [7:0]  hdr, hdr_nxt;
  logic [7:0]  sum_sr, sum_nxt;
  logic        sdo_nxt, busy_nxt, done_nxt;
  logic [3:0]  grant_nxt;
  logic [1:0]  cur_id_nxt;

  logic        found;
  logic [1:0]  gidx;
  logic [31:0] sel_word;
  logic [7:0]  chk;

  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] res;
    res = {1'b0, p};
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {found, gidx} = rr_pick(req, ptr);
    sel_word      = payload[32*gidx +: 32];
    chk           = sel_word[31:24] + sel_word[23:16] + sel_word[15:8] + sel_word[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      ptr    <= 2'd0;
      shreg  <= 32'd0;
      hdr    <= 8'd0;
      sum_sr <= 8'd0;
      sdo    <= 1'b0;
      grant  <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cur_id <= 2'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
      shreg  <= shreg_nxt;
      hdr    <= hdr_nxt;
      sum_sr <= sum_nxt;
      sdo    <= sdo_nxt;
      grant  <= grant_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      cur_id <= cur_id_nxt;
    end
  end

  // All outputs are registered: the state register names what sdo carries this cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 6'd1;
    ptr_nxt    = ptr;
    shreg_nxt  = shreg;
    hdr_nxt    = hdr;
    sum_nxt    = sum_sr;
    sdo_nxt    = 1'b0;
    grant_nxt  = 4'd0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    cur_id_nxt = cur_id;
    case (state)
      S_IDLE: begin
        cnt_nxt = 6'd0;
        if (found) begin
          grant_nxt  = 4'b0001 << gidx;
          shreg_nxt  = sel_word;
          sum_nxt    = chk;
          hdr_nxt    = HEAD_ALIGNED << 1;
          sdo_nxt    = HEAD_ALIGNED[7];
          cur_id_nxt = gidx;
          busy_nxt   = 1'b1;
          ptr_nxt    = gidx + 2'd1;
          state_nxt  = S_HEAD;
        end
      end
      S_HEAD: begin
        if (cnt == HEAD_LAST) begin
          state_nxt = S_DATA;
          cnt_nxt   = 6'd0;
          sdo_nxt   = shreg[31];
          shreg_nxt = shreg << 1;
        end else begin
          sdo_nxt = hdr[7];
          hdr_nxt = hdr << 1;
        end
      end
      S_DATA: begin
        if (cnt == DATA_LAST) begin
          state_nxt = S_SUM;
          cnt_nxt   = 6'd0;
          sdo_nxt   = sum_sr[7];
          sum_nxt   = sum_sr << 1;
        end else begin
          sdo_nxt   = shreg[31];
          shreg_nxt = shreg << 1;
        end
      end
      S_SUM: begin
        if (cnt == SUM_LAST) begin
          state_nxt = S_GAP;
          cnt_nxt   = 6'd0;
        end else begin
          sdo_nxt  = sum_sr[7];
          sum_nxt  = sum_sr << 1;
          done_nxt = (cnt == SUM_LAST - 6'd1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 6'd0;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 6'd0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
